// File: rtl/mem_principal_resp.sv
// Backing-memory responder for the 2-way set-associative cache.
// Serves line fills and dirty-victim write-backs over a four-phase req/ack link.
module mem_principal_resp #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int LATENCIA = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] end_leitura,
    input  logic [ADDR_W-1:0] end_escrita,
    input  logic [DATA_W-1:0] dado_escrita,
    output logic              ack,
    output logic [DATA_W-1:0] dado_leitura,
    output logic              ocupado,
    output logic              erro
);

    localparam int PROF  = 1 << ADDR_W;
    localparam int CNT_W = (LATENCIA < 1) ? 1 : $clog2(LATENCIA + 1);
    localparam logic [CNT_W-1:0] CNT_INI = CNT_W'(LATENCIA - 1);

    localparam logic [1:0] OP_LEITURA  = 2'b00;
    localparam logic [1:0] OP_ESCRITA  = 2'b01;
    localparam logic [1:0] OP_ESC_LEIT = 2'b10;
    localparam logic [1:0] OP_RESERV   = 2'b11;

    typedef enum logic [1:0] {
        OCIOSO,
        ESCRITA,
        LEITURA,
        AGUARDA_SOLTA
    } estado_t;

    estado_t estado, estado_d;

    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] el_q;
    logic [ADDR_W-1:0] ee_q;
    logic [DATA_W-1:0] de_q;
    logic              pend_erro, pend_erro_d;
    logic              ack_d;
    logic              erro_d;
    logic              ocupado_d;
    logic              captura;
    logic              grava;
    logic              le;

    logic [DATA_W-1:0] mem [PROF];

    // State register, captured transaction and memory array.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= OCIOSO;
            cnt          <= '0;
            op_q         <= '0;
            el_q         <= '0;
            ee_q         <= '0;
            de_q         <= '0;
            pend_erro    <= 1'b0;
            ack          <= 1'b0;
            erro         <= 1'b0;
            ocupado      <= 1'b0;
            dado_leitura <= '0;
            for (int i = 0; i < PROF; i++) begin
                mem[i] <= DATA_W'(i);
            end
        end else begin
            estado    <= estado_d;
            cnt       <= cnt_d;
            pend_erro <= pend_erro_d;
            ack       <= ack_d;
            erro      <= erro_d;
            ocupado   <= ocupado_d;
            if (captura) begin
                op_q <= op;
                el_q <= end_leitura;
                ee_q <= end_escrita;
                de_q <= dado_escrita;
            end
            if (grava) begin
                mem[ee_q] <= de_q;
            end
            if (le) begin
                dado_leitura <= mem[el_q];
            end
        end
    end

    // Next state and registered-output values.
    always_comb begin
        estado_d    = estado;
        cnt_d       = cnt;
        pend_erro_d = pend_erro;
        ack_d       = 1'b0;
        erro_d      = 1'b0;
        ocupado_d   = ocupado;
        captura     = 1'b0;
        grava       = 1'b0;
        le          = 1'b0;

        unique case (estado)
            OCIOSO: begin
                if (req) begin
                    captura   = 1'b1;
                    ocupado_d = 1'b1;
                    cnt_d     = CNT_INI;
                    unique case (op)
                        OP_LEITURA: estado_d = LEITURA;
                        OP_ESCRITA,
                        OP_ESC_LEIT: estado_d = ESCRITA;
                        OP_RESERV: begin
                            estado_d    = AGUARDA_SOLTA;
                            pend_erro_d = 1'b1;
                        end
                        default: estado_d = OCIOSO;
                    endcase
                end
            end

            ESCRITA: begin
                if (cnt == '0) begin
                    grava = 1'b1;
                    if (op_q == OP_ESC_LEIT) begin
                        estado_d = LEITURA;
                        cnt_d    = CNT_INI;
                    end else begin
                        estado_d  = AGUARDA_SOLTA;
                        ack_d     = 1'b1;
                        ocupado_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end

            LEITURA: begin
                if (cnt == '0) begin
                    le        = 1'b1;
                    estado_d  = AGUARDA_SOLTA;
                    ack_d     = 1'b1;
                    ocupado_d = 1'b0;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end

            AGUARDA_SOLTA: begin
                // Reserved op answers here, one cycle after accept.
                if (pend_erro) begin
                    pend_erro_d = 1'b0;
                    ack_d       = 1'b1;
                    erro_d      = 1'b1;
                    ocupado_d   = 1'b0;
                end else if (!req) begin
                    estado_d = OCIOSO;
                end
            end

            default: estado_d = OCIOSO;
        endcase
    end

endmodule

// File: tb/tb_mem_principal_resp.sv
// Directed bench for mem_principal_resp: table of transactions with
// hand-computed latency and read data, plus reset-abort sequence.
module tb_mem_principal_resp;

    logic       clock;
    logic       reset;
    logic       req;
    logic [1:0] op;
    logic [3:0] end_leitura;
    logic [3:0] end_escrita;
    logic [7:0] dado_escrita;
    logic       ack;
    logic [7:0] dado_leitura;
    logic       ocupado;
    logic       erro;

    int checks;
    int failures;

    mem_principal_resp dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .op           (op),
        .end_leitura  (end_leitura),
        .end_escrita  (end_escrita),
        .dado_escrita (dado_escrita),
        .ack          (ack),
        .dado_leitura (dado_leitura),
        .ocupado      (ocupado),
        .erro         (erro)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] op;
        logic [3:0] rl;
        logic [3:0] wl;
        logic [7:0] dw;
        int         hold;
        int         lat;
        logic [7:0] dl;
        logic       er;
    } vec_t;

    vec_t tab [10];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_txn(input vec_t v);
        int cyc;
        bit seen;
        bit busy_ok;
        @(negedge clock);
        op           = v.op;
        end_leitura  = v.rl;
        end_escrita  = v.wl;
        dado_escrita = v.dw;
        req          = 1'b1;
        @(posedge clock);
        #1;
        chk("ocupado_after_accept", 32'(ocupado), 32'd1);
        @(negedge clock);
        op           = ~v.op;
        end_leitura  = ~v.rl;
        end_escrita  = ~v.wl;
        dado_escrita = ~v.dw;
        seen    = 1'b0;
        busy_ok = 1'b1;
        cyc     = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clock);
            #1;
            if (ack === 1'b1) begin
                seen = 1'b1;
                cyc  = i;
            end else if (ocupado !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
        chk("ocupado_while_busy", 32'(busy_ok), 32'd1);
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: got no ack expected ack within 20 cycles");
        end else begin
            chk("ack_latency", 32'(cyc), 32'(v.lat));
            chk("dado_leitura", 32'(dado_leitura), 32'(v.dl));
            chk("erro_with_ack", 32'(erro), 32'(v.er));
            chk("ocupado_at_ack", 32'(ocupado), 32'd0);
            for (int h = 0; h < v.hold; h++) begin
                @(posedge clock);
                #1;
                chk("ack_single_pulse", 32'({ack, erro, ocupado}), 32'd0);
            end
            chk("dado_leitura_held", 32'(dado_leitura), 32'(v.dl));
        end
        @(negedge clock);
        req = 1'b0;
        @(posedge clock);
        #1;
        chk("idle_no_ack", 32'({ack, ocupado}), 32'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        req          = 1'b0;
        op           = 2'b00;
        end_leitura  = '0;
        end_escrita  = '0;
        dado_escrita = '0;

        //          op     rl     wl     dw     hold lat dl     er
        tab[0] = '{2'b00, 4'd5,  4'd0,  8'h00, 1,   3,  8'h05, 1'b0};
        tab[1] = '{2'b01, 4'd0,  4'd2,  8'hA7, 1,   3,  8'h05, 1'b0};
        tab[2] = '{2'b00, 4'd2,  4'd0,  8'h00, 1,   3,  8'hA7, 1'b0};
        tab[3] = '{2'b10, 4'd9,  4'd9,  8'h3C, 1,   6,  8'h3C, 1'b0};
        tab[4] = '{2'b11, 4'd0,  4'd0,  8'h00, 2,   1,  8'h3C, 1'b1};
        tab[5] = '{2'b00, 4'd3,  4'd0,  8'h00, 10,  3,  8'h03, 1'b0};
        tab[6] = '{2'b00, 4'd1,  4'd0,  8'h00, 1,   3,  8'h01, 1'b0};
        tab[7] = '{2'b10, 4'd2,  4'd1,  8'h55, 1,   6,  8'hA7, 1'b0};
        tab[8] = '{2'b00, 4'd1,  4'd0,  8'h00, 1,   3,  8'h55, 1'b0};
        tab[9] = '{2'b00, 4'd15, 4'd0,  8'h00, 1,   3,  8'h0F, 1'b0};

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset_outputs", 32'({ack, erro, ocupado}), 32'd0);
        chk("reset_dado_leitura", 32'(dado_leitura), 32'd0);

        for (int k = 0; k < 10; k++) begin
            do_txn(tab[k]);
        end

        // Reset two edges into a write-back aborts it without an ack.
        @(negedge clock);
        op           = 2'b01;
        end_escrita  = 4'd4;
        dado_escrita = 8'hFF;
        req          = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_outputs", 32'({ack, erro, ocupado}), 32'd0);
        chk("abort_dado_leitura", 32'(dado_leitura), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        req   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            chk("abort_no_ack", 32'({ack, ocupado}), 32'd0);
        end

        do_txn('{2'b00, 4'd4, 4'd0, 8'h00, 1, 3, 8'h04, 1'b0});
        do_txn('{2'b00, 4'd2, 4'd0, 8'h00, 1, 3, 8'h02, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
